lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the bus-wait watchdog limit in cycles (used only with LSU_TIMEOUT_EN).
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 valid_i  input  1  instruction in MEM stage is valid.
REQ-005 mem_read_i / mem_write_i  input  1 each  load / store request from decode control.
REQ-006 funct3_i  input  3  access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 addr_i / wdata_i  input  32 each  effective address / store data.
REQ-008 dmem_req_o, dmem_we_o  output  1 each  bus request, write strobe.
REQ-009 dmem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-010 dmem_be_o  output  4; dmem_wdata_o  output  32  byte enables, lane-replicated data.
REQ-011 dmem_gnt_i, dmem_rvalid_i  input  1 each; dmem_rdata_i  input  32  bus grant, read-data valid, read data.
REQ-012 stall_o, done_o, err_o  output  1 each; rdata_o  output  32  pipeline stall, completion pulse, error pulse, extended load data.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-014 IDLE: accept when valid_i & (mem_read_i|mem_write_i) & legal & aligned; latch addr, wdata, funct3, we; go REQ; stall_o=1 combinationally in the accept cycle.
REQ-015 mem_read_i and mem_write_i both high SHALL be treated as a store.
REQ-016 Misaligned (H with addr[0]=1; W with addr[1:0]!=0) or illegal funct3 (011, 110, 111, or store with 1xx) SHALL pulse err_o one cycle in IDLE, issue no bus request, leave stall_o low, stay IDLE.
REQ-017 REQ: dmem_req_o=1 with stable latched addr/be/wdata/we until dmem_gnt_i; stall_o=1.
REQ-018 On grant: store -> DONE; load with dmem_rvalid_i same cycle -> capture, DONE; else -> WAIT.
REQ-019 WAIT: dmem_req_o=0, stall_o=1; on dmem_rvalid_i capture data, go DONE.
REQ-020 DONE: done_o=1 for exactly one cycle, stall_o=0, go IDLE; a new access SHALL NOT be accepted in DONE.
REQ-021 dmem_be_o: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<{addr[1],1'b0}; W -> 4'b1111; dmem_wdata_o replicates byte/half across lanes.
REQ-022 rdata_o: selected lane shifted to bit 0; B/H sign-extended, BU/HU zero-extended, W unmodified; held until next load completes.
REQ-023 dmem_rvalid_i outside REQ/WAIT SHALL be ignored.
REQ-024 Store best case: accept cycle 0, grant cycle 1, done_o cycle 2; stall_o high cycles 0-1.

Reset
REQ-025 rst_i high SHALL force IDLE at next edge, aborting any in-flight access, even mid-REQ/WAIT.
REQ-026 Reset values: dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0, stall_o=0, done_o=0, err_o=0, rdata_o=0, watchdog=0.

Configuration
REQ-027 Macro LSU_TIMEOUT_EN defined: a counter SHALL run in REQ/WAIT, clear on entering REQ; at TIMEOUT_CYCLES without completion pulse err_o one cycle, deassert request, go IDLE, rdata_o unchanged, done_o not asserted.
REQ-028 LSU_TIMEOUT_EN undefined: no counter; REQ/WAIT SHALL wait indefinitely.

Verification
REQ-029 SW funct3=010 addr=0x100 wdata=0xDEADBEEF, gnt cycle 1 -> be=1111, addr=0x100, we=1, done_o cycle 2, stall_o high cycles 0-1.
REQ-030 LB addr=0x203, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x80FFFFFF -> rdata_o=0xFFFFFF80, be=1000; LBU same -> 0x00000080.
REQ-031 LW addr=0x102 -> err_o one cycle, dmem_req_o stays 0, stall_o 0, FSM IDLE.
REQ-032 SH addr=0x6 wdata=0x0000ABCD -> be=1100, dmem_wdata_o=0xABCDABCD.
REQ-033 LW in WAIT, rst_i high one cycle -> IDLE, all outputs at reset values; later rvalid ignored.
REQ-034 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, gnt never asserted -> err_o at 16th REQ cycle, req drops, no done_o.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_ctrl_if -- data-memory bus between the load/store unit and memory.
//
// Signals (suffixes are from the LSU's point of view):
//   dmem_req_o     LSU -> mem   access request, held until granted
//   dmem_we_o      LSU -> mem   1 = store, 0 = load
//   dmem_addr_o    LSU -> mem   word-aligned address
//   dmem_be_o      LSU -> mem   byte enables
//   dmem_wdata_o   LSU -> mem   store data, replicated across lanes
//   dmem_gnt_i     mem -> LSU   request accepted
//   dmem_rvalid_i  mem -> LSU   read data valid
//   dmem_rdata_i   mem -> LSU   read data (full word)
//
// Modports: master (LSU side), slave (memory side).
// ---------------------------------------------------------------------------
interface lsu_ctrl_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_be_o,
        output dmem_wdata_o,
        input  dmem_gnt_i,
        input  dmem_rvalid_i,
        input  dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_be_o,
        input  dmem_wdata_o,
        output dmem_gnt_i,
        output dmem_rvalid_i,
        output dmem_rdata_i
    );
endinterface

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- MEM-stage load/store controller.
//
// Accepts one load or store from the pipeline, drives it onto the data bus
// (request/grant, then read-valid for loads), stalls the pipeline while the
// access is outstanding and returns size/sign-extended load data.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   valid_i              MEM-stage instruction valid
//   mem_read_i           load request
//   mem_write_i          store request (wins if both are high)
//   funct3_i             access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i, wdata_i      effective address, store data
//   dmem                 data bus (lsu_ctrl_if.master)
//   stall_o              pipeline stall
//   done_o               one-cycle completion pulse
//   err_o                one-cycle error pulse (illegal/misaligned/timeout)
//   rdata_o              extended load data, held until the next load ends
//
// Parameter:
//   TIMEOUT_CYCLES       bus-wait watchdog limit (only with LSU_TIMEOUT_EN)
//
// Build option:
//   LSU_TIMEOUT_EN       when defined, an access that sits in REQ/WAIT for
//                        TIMEOUT_CYCLES cycles is abandoned with err_o.
//                        When undefined the controller waits indefinitely.
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    lsu_ctrl_if.master  dmem,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Access latched at accept time; drives the bus for the whole access.
    logic [31:0] r_addr;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_access;
    logic        w_legal;
    logic        w_aligned;
    logic        w_accept;
    logic        w_capture;
    logic        w_expire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_ext;

    // A request only counts outside reset so a reset cycle never pulses err_o.
    assign w_access = valid_i & (mem_read_i | mem_write_i) & ~rst_i;

    // ------------------------------------------------------------------
    // Request decode: legality, alignment, byte enables, lane data
    // ------------------------------------------------------------------
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b0;
        w_be      = 4'b1111;
        w_wdata   = wdata_i;

        // Unsigned variants only exist for loads; a store with both read
        // and write high is treated as a store and so rejects 1xx too.
        case (funct3_i)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~mem_write_i;
            default:                w_legal = 1'b0;
        endcase

        case (funct3_i[1:0])
            2'b00: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << addr_i[1:0];
                w_wdata   = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_aligned = ~addr_i[0];
                w_be      = 4'b0011 << {addr_i[1], 1'b0};
                w_wdata   = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                w_aligned = (addr_i[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = wdata_i;
            end
            default: begin
                w_aligned = 1'b0;
                w_be      = 4'b1111;
                w_wdata   = wdata_i;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data extraction: move the addressed lane to bit 0, then extend
    // ------------------------------------------------------------------
    assign w_shifted = dmem.dmem_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_ext = dmem.dmem_rdata_i;
        case (r_f3)
            3'b000:  w_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ext = {24'b0, w_shifted[7:0]};
            3'b101:  w_ext = {16'b0, w_shifted[15:0]};
            default: w_ext = dmem.dmem_rdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus-wait watchdog
    // ------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
    localparam int unsigned        WDOG_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic              w_busy;
    logic [WDOG_W-1:0] r_wdog;

    assign w_busy = (r_state == REQ) || (r_state == WAIT);

    // Counter is zero in the first REQ cycle (it is held at zero in IDLE),
    // so the limit is reached in the TIMEOUT_CYCLES-th REQ/WAIT cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wdog <= '0;
        end else if (w_busy) begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_expire = w_busy & (r_wdog == WDOG_LAST);
`else
    logic w_unused;

    assign w_expire = 1'b0;
    assign w_unused = (TIMEOUT_CYCLES == 0);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next          = r_state;
        w_accept        = 1'b0;
        w_capture       = 1'b0;
        dmem.dmem_req_o = 1'b0;
        stall_o         = 1'b0;
        done_o          = 1'b0;
        err_o           = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_legal && w_aligned) begin
                        w_accept = 1'b1;
                        stall_o  = 1'b1;
                        w_next   = REQ;
                    end else begin
                        err_o = 1'b1;
                    end
                end
            end
            REQ: begin
                dmem.dmem_req_o = 1'b1;
                stall_o         = 1'b1;
                // A grant in the last watchdog cycle still completes.
                if (dmem.dmem_gnt_i) begin
                    if (r_we) begin
                        w_next = DONE;
                    end else if (dmem.dmem_rvalid_i) begin
                        w_capture = 1'b1;
                        w_next    = DONE;
                    end else begin
                        w_next = WAIT;
                    end
                end else if (w_expire) begin
                    err_o  = 1'b1;
                    w_next = IDLE;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (dmem.dmem_rvalid_i) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end else if (w_expire) begin
                    err_o  = 1'b1;
                    w_next = IDLE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched access and load result
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_off   <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= {addr_i[31:2], 2'b00};
                r_off   <= addr_i[1:0];
                r_f3    <= funct3_i;
                r_we    <= mem_write_i;
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
            if (w_capture) begin
                r_rdata <= w_ext;
            end
        end
    end

    assign dmem.dmem_we_o    = r_we;
    assign dmem.dmem_addr_o  = r_addr;
    assign dmem.dmem_be_o    = r_be;
    assign dmem.dmem_wdata_o = r_wdata;
    assign rdata_o           = r_rdata;

endmodule
